autobaud_detect: RTL and testbench

Measures the bit period of an incoming asynchronous serial line from a single sync character 0x55 ('U') and reports it as a cycle count plus a half-period divisor value. It is the measuring counterpart of the team's fixed-modulus clock dividers: a divider turns a modulus into a frequency, and this block turns an observed frequency back into a modulus. The block sits between the raw RX pin and a programmable baud divider or UART receiver, and is armed by the channel controller before a link is brought up.

---
 rtl/autobaud_detect_pkg.sv | 22 ++
 rtl/autobaud_detect_edge_sync.sv | 33 +++
 rtl/autobaud_detect.sv | 143 ++++++++++++++
 tb/tb_autobaud_detect.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/autobaud_detect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | autobaud_detect_pkg                                                  |
// | State encoding and sync character shared by autobaud_detect and TBs. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package autobaud_detect_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } abd_state_t;

   localparam logic [7:0] SYNC_CHAR = 8'h55;

   // 0x55 yields five falling edges; the fifth closes the fourth interval
   localparam logic [2:0] c_first_edge = 3'd1;
   localparam logic [2:0] c_last_edge  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/autobaud_detect_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_sync                                                            |
// | Multi-flop synchroniser with a registered falling-edge detector.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic rx_in,
   output logic fe
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Flops reset to the idle-high level so leaving reset never looks like an edge
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign fe = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/autobaud_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | autobaud_detect                                                      |
// | Measures the RX bit period from one 0x55 sync character.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module autobaud_detect
   import autobaud_detect_pkg::*;
#(
   parameter int CNT_W        = 20,
   parameter int SYNC_STAGES  = 2,
   parameter int MIN_INTERVAL = 16
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             rx_in,
   input  logic             arm,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             valid,
   output logic [CNT_W-1:0] bit_period,
   output logic [CNT_W-1:0] half_div
);

   logic w_fe;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .rx_in  (rx_in),
      .fe     (w_fe)
   );

   abd_state_t       r_state;
   logic [CNT_W-1:0] r_span_cnt;
   logic [CNT_W-1:0] r_int_cnt;
   logic [CNT_W:0]   r_ref_int;
   logic [2:0]       r_edge_idx;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_valid;
   logic [CNT_W-1:0] r_bit_period;
   logic [CNT_W-1:0] r_half_div;

   // Interval arithmetic is one bit wider so the difference cannot wrap
   logic [CNT_W:0]   w_int_len;
   logic [CNT_W:0]   w_span_rnd;
   logic [CNT_W:0]   w_diff;
   logic [CNT_W-1:0] w_period;
   logic             w_tol_ok;
   logic             w_min_ok;
   logic             w_edge_ok;
   logic             w_timeout;

   assign w_int_len  = {1'b0, r_int_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_span_rnd = {1'b0, r_span_cnt} + (CNT_W+1)'(5);
   assign w_period   = CNT_W'(w_span_rnd >> 3);
   assign w_diff     = (w_int_len >= r_ref_int) ? (w_int_len - r_ref_int)
                                                : (r_ref_int - w_int_len);
   assign w_tol_ok   = (w_diff <= (r_ref_int >> 3));
   assign w_min_ok   = (w_int_len >= (CNT_W+1)'(MIN_INTERVAL));
   assign w_edge_ok  = w_min_ok && ((r_edge_idx == c_first_edge) || w_tol_ok);
   assign w_timeout  = &r_int_cnt;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_span_cnt   <= '0;
         r_int_cnt    <= '0;
         r_ref_int    <= '0;
         r_edge_idx   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_valid      <= 1'b0;
         r_bit_period <= '0;
         r_half_div   <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (arm) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ARMED;
               end
            end
            ARMED: begin
               if (arm) begin
                  r_valid <= 1'b0;
               end
               if (w_fe) begin
                  r_span_cnt <= '0;
                  r_int_cnt  <= '0;
                  r_edge_idx <= c_first_edge;
                  r_state    <= MEASURE;
               end
            end
            MEASURE: begin
               r_span_cnt <= r_span_cnt + 1'b1;
               r_int_cnt  <= r_int_cnt + 1'b1;
               // Timeout takes precedence over a coincident edge
               if (w_timeout || (w_fe && !w_edge_ok)) begin
                  r_err   <= 1'b1;
                  r_busy  <= arm;
                  r_state <= arm ? ARMED : IDLE;
               end else if (w_fe && (r_edge_idx == c_last_edge)) begin
                  r_done       <= 1'b1;
                  r_valid      <= 1'b1;
                  r_bit_period <= w_period;
                  r_half_div   <= w_period >> 1;
                  r_busy       <= arm;
                  r_state      <= arm ? ARMED : IDLE;
               end else if (w_fe) begin
                  if (r_edge_idx == c_first_edge) begin
                     r_ref_int <= w_int_len;
                  end
                  r_int_cnt  <= '0;
                  r_edge_idx <= r_edge_idx + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign valid      = r_valid;
   assign bit_period = r_bit_period;
   assign half_div   = r_half_div;

endmodule
`default_nettype wire

// File: tb/tb_autobaud_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_autobaud_detect                                                   |
// | Directed self-checking bench for autobaud_detect (CNT_W=13).         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_autobaud_detect;

   localparam int CNT_W = 13;

   logic             clk_in = 1'b0;
   logic             rst_n  = 1'b0;
   logic             rx_in  = 1'b1;
   logic             arm    = 1'b0;
   logic             busy;
   logic             done;
   logic             err;
   logic             valid;
   logic [CNT_W-1:0] bit_period;
   logic [CNT_W-1:0] half_div;

   int n_cmp    = 0;
   int n_mis    = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int d0, e0;
   int wd[10];

   autobaud_detect #(
      .CNT_W        (CNT_W),
      .SYNC_STAGES  (2),
      .MIN_INTERVAL (16)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .rx_in      (rx_in),
      .arm        (arm),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .valid      (valid),
      .bit_period (bit_period),
      .half_div   (half_div)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic drive_level(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk_in);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge clk_in);
      arm = 1'b0;
   endtask

   // Start bit, eight data bits LSB first, stop bit, each with its own width
   task automatic send_widths(input logic [7:0] ch);
      logic [9:0] fr;
      fr = {1'b1, ch, 1'b0};
      for (int i = 0; i < 10; i++) drive_level(fr[i], wd[i]);
      idle(20);
   endtask

   task automatic send_frame(input logic [7:0] ch, input int w);
      for (int i = 0; i < 10; i++) wd[i] = w;
      send_widths(ch);
   endtask

   task automatic wait_err(input int base, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (err_cnt != base) break;
         @(negedge clk_in);
      end
   endtask

   initial begin
      logic [9:0] fr;
      idle(5);
      rst_n = 1'b1;
      idle(2);

      chk("rst_busy",  busy,       0);
      chk("rst_done",  done,       0);
      chk("rst_err",   err,        0);
      chk("rst_valid", valid,      0);
      chk("rst_bp",    bit_period, 0);
      chk("rst_half",  half_div,   0);

      // Nominal 217 cycles/bit, with an arm pulse during MEASURE that must be ignored
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      idle(2);
      chk("nom_busy_armed", busy, 1);
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            drive_level(fr[i], 100);
            pulse_arm();
            drive_level(fr[i], 116);
         end else begin
            drive_level(fr[i], 217);
         end
      end
      idle(20);
      chk("nom_done", done_cnt - d0, 1);
      chk("nom_err",  err_cnt - e0,  0);
      chk("nom_valid", valid, 1);
      chk("nom_bp",   bit_period, 217);
      chk("nom_half", half_div,   108);
      chk("nom_busy", busy, 0);

      // Jittered bits, 8-bit span 2404 -> rounds to 301
      wd = '{310, 300, 290, 300, 300, 310, 290, 304, 300, 300};
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      chk("jit_valid_clr", valid, 0);
      send_widths(8'h55);
      chk("jit_done", done_cnt - d0, 1);
      chk("jit_err",  err_cnt - e0,  0);
      chk("jit_bp",   bit_period, 301);
      chk("jit_half", half_div,   150);

      // Wrong character 0x0F: too few edges, ends in timeout
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      send_frame(8'h0F, 217);
      wait_err(e0, 10000);
      idle(2);
      chk("wrong_err",   err_cnt - e0,  1);
      chk("wrong_done",  done_cnt - d0, 0);
      chk("wrong_valid", valid, 0);
      chk("wrong_bp",    bit_period, 301);
      chk("wrong_busy",  busy, 0);

      // Second interval 717 vs reference 434 exceeds tolerance 54
      wd = '{217, 217, 500, 217, 217, 217, 217, 217, 217, 217};
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      send_widths(8'h55);
      chk("tol_err",  err_cnt - e0,  1);
      chk("tol_done", done_cnt - d0, 0);
      chk("tol_half", half_div, 150);

      // Two 5-cycle glitches: 10-cycle interval is below MIN_INTERVAL
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      drive_level(1'b0, 5);
      drive_level(1'b1, 5);
      drive_level(1'b0, 5);
      drive_level(1'b1, 20);
      chk("glitch_err",  err_cnt - e0,  1);
      chk("glitch_done", done_cnt - d0, 0);
      chk("glitch_bp",   bit_period, 301);
      d0 = done_cnt;
      pulse_arm();
      send_frame(8'h55, 217);
      chk("reglitch_done", done_cnt - d0, 1);
      chk("reglitch_bp",   bit_period, 217);

      // Timeout: one edge, line stays high, err at int_cnt = 8191
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      drive_level(1'b0, 217);
      drive_level(1'b1, 7000);
      chk("to_early_err", err_cnt - e0, 0);
      chk("to_busy_wait", busy, 1);
      wait_err(e0, 3000);
      idle(2);
      chk("to_err",  err_cnt - e0,  1);
      chk("to_done", done_cnt - d0, 0);
      chk("to_busy", busy, 0);

      // Reset pulse right after the third falling edge
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      drive_level(1'b0, 217);
      drive_level(1'b1, 217);
      drive_level(1'b0, 217);
      drive_level(1'b1, 217);
      drive_level(1'b0, 4);
      rst_n = 1'b0;
      @(negedge clk_in);
      rst_n = 1'b1;
      chk("rstm_busy",  busy,       0);
      chk("rstm_valid", valid,      0);
      chk("rstm_bp",    bit_period, 0);
      chk("rstm_half",  half_div,   0);
      drive_level(1'b0, 212);
      for (int i = 4; i < 10; i++) drive_level(fr[i], 217);
      idle(20);
      chk("rstm_done", done_cnt - d0, 0);
      chk("rstm_err",  err_cnt - e0,  0);

      // Slow rate, 1000 cycles/bit
      d0 = done_cnt; e0 = err_cnt;
      pulse_arm();
      send_frame(8'h55, 1000);
      chk("slow_done",  done_cnt - d0, 1);
      chk("slow_err",   err_cnt - e0,  0);
      chk("slow_bp",    bit_period, 1000);
      chk("slow_half",  half_div,   500);
      chk("slow_valid", valid, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
